// File: rtl/nfc_cmd_arbiter.sv
// Round-robin arbiter sharing one NAND flash controller among NUM_REQ requesters.
// A watchdog aborts stalled transfers; cmd_cnt counts successful completions.
module nfc_cmd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 4096,
    parameter int TW      = $clog2(TIMEOUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [33*NUM_REQ-1:0]  cmd_in,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     cpl,
    output logic                   cpl_err,
    output logic [32:0]            nfc_cmd,
    output logic                   nfc_start,
    input  logic                   nfc_done,
    output logic                   busy,
    output logic [15:0]            cmd_cnt
);
    // state | meaning
    // IDLE  | no transfer; pick next requester round-robin from rr_ptr
    // ISSUE | one-cycle start strobe to NFC and grant pulse to sel
    // WAIT  | wait for nfc_done while the watchdog counts down
    // CPL   | one-cycle completion pulse to sel, cpl_err from err_flag
    localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CPL} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] rr_ptr, rr_ptr_nxt;
    logic [SW-1:0] sel, sel_nxt;
    logic [32:0]   cur_cmd, cur_cmd_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          err_flag, err_flag_nxt;
    logic [15:0]   cnt_nxt;
    logic          found;
    logic [SW-1:0] pick;
    logic [32:0]   pick_cmd;

    always_comb begin : rr_search
        int idx;
        found = 1'b0;
        pick  = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = SW'(idx);
            end
        end
    end

    always_comb begin
        pick_cmd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == SW'(i)) pick_cmd = cmd_in[33*i +: 33];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            sel      <= '0;
            cur_cmd  <= '0;
            timer    <= '0;
            err_flag <= 1'b0;
            cmd_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            sel      <= sel_nxt;
            cur_cmd  <= cur_cmd_nxt;
            timer    <= timer_nxt;
            err_flag <= err_flag_nxt;
            cmd_cnt  <= cnt_nxt;
        end
    end

    // Watchdog is a down-counter: loaded with TIMEOUT-1 on issue, abort on reaching zero.
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        sel_nxt      = sel;
        cur_cmd_nxt  = cur_cmd;
        timer_nxt    = timer;
        err_flag_nxt = err_flag;
        cnt_nxt      = cmd_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    sel_nxt     = pick;
                    cur_cmd_nxt = pick_cmd;
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                rr_ptr_nxt = (sel == SW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
                timer_nxt  = TW'(TIMEOUT - 1);
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (nfc_done) begin
                    err_flag_nxt = 1'b0;
                    cnt_nxt      = cmd_cnt + 16'd1;
                    state_nxt    = CPL;
                end else if (timer == '0) begin
                    err_flag_nxt = 1'b1;
                    state_nxt    = CPL;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            CPL:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt = '0;
        cpl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = (state == ISSUE) && (sel == SW'(i));
            cpl[i] = (state == CPL) && (sel == SW'(i));
        end
    end

    assign nfc_start = (state == ISSUE);
    assign cpl_err   = (state == CPL) && err_flag;
    assign busy      = (state != IDLE);
    assign nfc_cmd   = cur_cmd;

endmodule

// File: tb/tb_nfc_cmd_arbiter.sv
// Self-checking bench for nfc_cmd_arbiter: vector table, directed corner sequences,
// and randomized traffic compared against a transaction-level reference model.
module tb_nfc_cmd_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [33*N-1:0]  cmd_in;
    logic [N-1:0]     gnt, cpl;
    logic             cpl_err;
    logic [32:0]      nfc_cmd;
    logic             nfc_start, nfc_done, busy;
    logic [15:0]      cmd_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nfc_cmd_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .cmd_in(cmd_in),
        .gnt(gnt), .cpl(cpl), .cpl_err(cpl_err), .nfc_cmd(nfc_cmd),
        .nfc_start(nfc_start), .nfc_done(nfc_done), .busy(busy), .cmd_cnt(cmd_cnt)
    );

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic         done;
        logic [N-1:0] gnt;
        logic [N-1:0] cpl;
        logic         err;
        logic         busy;
        logic [15:0]  cnt;
        int           port;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] obs();
        return {4'b0, gnt, cpl, cpl_err, nfc_start, busy, cmd_cnt, nfc_cmd};
    endfunction

    function automatic logic [32:0] cmdw(input int i);
        return {1'(i & 1), 18'(32'h00105 + 32'h1111 * i), 7'(3 + i), 7'(5 + 11 * i)};
    endfunction

    task automatic set_cmds();
        for (int i = 0; i < N; i++) cmd_in[33*i +: 33] = cmdw(i);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; nfc_done = 1'b0;
        tick();
        chk("reset outputs", obs(), 64'h0);
        rst = 1'b0;
    endtask

    // One full transfer from IDLE; done_at = WAIT cycle carrying nfc_done, 0 = never.
    task automatic run_xfer(input string name, input logic [N-1:0] reqv, input int port,
                            input int done_at, input bit stale, input logic [15:0] exp_cnt);
        logic [32:0] w;
        bit early;
        int wlen;
        w = cmd_in[33*port +: 33];
        wlen = (done_at != 0) ? done_at : TO;
        req = reqv; nfc_done = stale;
        tick();
        chk({name, " gnt"}, 64'(gnt), 64'(1 << port));
        chk({name, " start/cmd"}, 64'({nfc_start, busy, nfc_cmd}), 64'({2'b11, w}));
        req[port] = 1'b0;
        cmd_in[33*port +: 33] = ~w;
        early = 1'b0;
        for (int k = 1; k <= wlen; k++) begin
            tick();
            nfc_done = (k == done_at);
            if (cpl != '0 || !busy || gnt != '0) early = 1'b1;
        end
        tick();
        nfc_done = stale;
        chk({name, " wait phase"}, 64'(early), 64'(0));
        chk({name, " cpl"}, 64'({cpl, cpl_err, cmd_cnt, nfc_cmd}),
            64'({4'(1 << port), done_at == 0, exp_cnt, w}));
        tick();
        nfc_done = 1'b0;
        chk({name, " idle"}, 64'({busy, cpl, cmd_cnt, nfc_cmd}), 64'({1'b0, 4'b0, exp_cnt, w}));
        cmd_in[33*port +: 33] = w;
    endtask

    // Reference model: each granted transfer is a record {start, cpl cycle, owner, err, cmd};
    // the arbiter is free again the cycle after its completion.
    task automatic random_test(input int ncyc);
        bit have, t_err, found;
        int t_start, t_cpl, t_done, who, rr, free_at, d;
        logic [32:0] t_cmd;
        logic [15:0] m_cnt;
        bit pend[N];
        logic [32:0] wc[N];
        logic [N-1:0] rv;
        logic [63:0] exp;
        have = 0; t_err = 0; t_start = -10; t_cpl = -10; t_done = -1; who = 0;
        rr = 0; free_at = 0; t_cmd = '0; m_cnt = '0; rv = '0;
        for (int i = 0; i < N; i++) begin pend[i] = 0; wc[i] = '0; end
        for (int c = 0; c < ncyc; c++) begin
            if (have && c == t_cpl && !t_err) m_cnt = m_cnt + 16'd1;
            exp = {4'b0,
                   (have && c == t_start) ? 4'(1 << who) : 4'b0,
                   (have && c == t_cpl) ? 4'(1 << who) : 4'b0,
                   have && c == t_cpl && t_err,
                   have && c == t_start,
                   have && c >= t_start && c <= t_cpl,
                   m_cnt,
                   have ? t_cmd : 33'd0};
            chk($sformatf("random c=%0d", c), obs(), exp);
            for (int i = 0; i < N; i++) begin
                if (have && i == who && c == t_start + 1) pend[i] = 0;
                if (!pend[i]) begin
                    wc[i] = 33'({$urandom, $urandom});
                    if (!(have && i == who && c <= t_cpl) && $urandom_range(0, 5) == 0) pend[i] = 1;
                end
                rv[i] = pend[i];
                cmd_in[33*i +: 33] = wc[i];
            end
            req = rv;
            if (have && c == t_done) nfc_done = 1'b1;
            else if (have && c > t_start && c < t_cpl) nfc_done = 1'b0;
            else nfc_done = ($urandom_range(0, 3) == 0);
            if (c >= free_at && rv != '0) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && rv[(rr + k) % N]) begin found = 1; who = (rr + k) % N; end
                end
                have = 1;
                t_start = c + 1;
                t_cmd = wc[who];
                case ($urandom_range(0, 7))
                    0:       d = 0;
                    1:       d = TO;
                    default: d = $urandom_range(1, TO - 1);
                endcase
                t_err = (d == 0);
                t_done = (d != 0) ? t_start + d : -1;
                t_cpl = t_start + ((d != 0) ? d : TO) + 1;
                free_at = t_cpl + 1;
                rr = (who + 1) % N;
            end
            tick();
        end
    endtask

    vec_t tbl[15];
    logic [32:0] ecmd;

    initial begin
        rst = 1'b1; req = '0; nfc_done = 1'b0; cmd_in = '0;
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'd0, -1};
        tbl[1]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'd0, -1};
        tbl[2]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 16'd0,  2};
        tbl[3]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 16'd0,  2};
        tbl[4]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 16'd0,  2};
        tbl[5]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b1, 16'd1,  2};
        tbl[6]  = '{1'b0, 4'b1001, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'd1,  2};
        tbl[7]  = '{1'b0, 4'b1001, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b1, 16'd1,  3};
        tbl[8]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 16'd1,  3};
        tbl[9]  = '{1'b0, 4'b0001, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b1, 16'd2,  3};
        tbl[10] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'd2,  3};
        tbl[11] = '{1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 16'd2,  0};
        tbl[12] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 16'd2,  0};
        tbl[13] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b1, 16'd3,  0};
        tbl[14] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'd3,  0};

        set_cmds();
        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].rst; req = tbl[i].req; nfc_done = tbl[i].done;
            tick();
            ecmd = (tbl[i].port < 0) ? 33'd0 : cmdw(tbl[i].port);
            chk($sformatf("vec%0d", i), obs(),
                {4'b0, tbl[i].gnt, tbl[i].cpl, tbl[i].err, tbl[i].gnt != '0,
                 tbl[i].busy, tbl[i].cnt, ecmd});
        end

        do_reset();
        cmd_in[32:0] = {1'b1, 18'h00105, 7'd3, 7'd5};
        run_xfer("single", 4'b0001, 0, 12, 0, 16'd1);
        set_cmds();

        do_reset();
        run_xfer("cont0", 4'b0101, 0, 3, 0, 16'd1);
        run_xfer("cont1", 4'b0101, 2, 5, 0, 16'd2);
        run_xfer("cont2", 4'b0101, 0, 1, 0, 16'd3);
        run_xfer("cont3", 4'b0101, 2, 7, 0, 16'd4);
        run_xfer("wdog", 4'b0010, 1, 0, 0, 16'd4);
        run_xfer("post_wdog", 4'b1000, 3, 2, 0, 16'd5);
        run_xfer("coinc", 4'b0001, 0, TO, 0, 16'd6);
        run_xfer("stale", 4'b0100, 2, 4, 1, 16'd7);

        req = 4'b0001;
        tick();
        chk("rst_mid gnt", 64'(gnt), 64'(4'b0001));
        req = '0;
        repeat (5) tick();
        rst = 1'b1; req = 4'b1010;
        tick();
        chk("rst_mid outputs", obs(), 64'h0);
        rst = 1'b0;
        run_xfer("post_rst", 4'b1010, 1, 3, 0, 16'd1);

        do_reset();
        random_test(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global time limit: checks=%0d", checks);
        $fatal(1, "time limit");
    end

endmodule
